// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and helpers for the buffered OTTER UART transmitter.
// PARITY is only reachable when UART_TX_PARITY_EN is defined.
package otter_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } tx_state_t;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic LINE_IDLE       = 1'b1;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO; rdata shows the head whenever empty=0.
// Storage is not reset; only pointers and count are.
module sync_fifo
  import otter_uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // full/empty come from the registered count, so a same-cycle pop never frees a slot
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter fed by the MMIO decoder's start strobe.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1, 11-bit frame).
module uart_tx_fifo
  import otter_uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       busy,
  output logic       Tx
);

  localparam int DIV   = baud_div(CLK_HZ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  tx_state_t        state;
  tx_state_t        state_nxt;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       head;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             pop;
  logic             bit_done;
  logic             tx_nxt;
`ifdef UART_TX_PARITY_EN
  logic             parity;
`endif

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (start),
    .pop   (pop),
    .wdata (data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign ready    = ~full;
  assign busy     = (state != IDLE) | (count != '0);
  assign bit_done = (baud_cnt == CNT_W'(DIV - 1));

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_nxt    = LINE_IDLE;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        tx_nxt = 1'b0;
        if (bit_done) state_nxt = DATA;
      end
      DATA: begin
        tx_nxt = shift[0];
        if (bit_done && bit_idx == 3'(FRAME_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_nxt = parity;
        if (bit_done) state_nxt = STOP;
      end
`endif
      STOP: begin
        // Reload straight from the FIFO on the last stop cycle so frames abut
        if (bit_done) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Tx is registered from the current state, so the line lags the FSM by one cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      Tx       <= LINE_IDLE;
    end else begin
      Tx <= tx_nxt;
      if (state == IDLE || bit_done) baud_cnt <= '0;
      else                           baud_cnt <= baud_cnt + CNT_W'(1);
      if (state != DATA)             bit_idx  <= '0;
      else if (bit_done)             bit_idx  <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (pop) begin
      shift  <= head;
`ifdef UART_TX_PARITY_EN
      parity <= ^head;
`endif
    end else if (state == DATA && bit_done) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo at DIV=10, FIFO_DEPTH=4; a Tx monitor decodes frames.
// Honours UART_TX_PARITY_EN to expect 11-bit frames and runs the parity vector.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DEPTH  = 4;
  localparam int DIV    = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS  = 11;
`else
  localparam int NBITS  = 10;
`endif
  localparam int FRAME_CYC = NBITS * DIV;

  logic       CLK   = 1'b0;
  logic       RST   = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       ready;
  logic       busy;
  logic       Tx;

  uart_tx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .start (start),
    .data  (data),
    .ready (ready),
    .busy  (busy),
    .Tx    (Tx)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  logic [7:0] exp_q[$];
  int         starts[$];
  bit         in_frame = 1'b0;
  int         pos;
  int         glitches;
  int         bidx;
  logic [7:0] cur;
  logic [7:0] rx;

  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Monitor: every cycle of a frame must carry exactly the expected line level
  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (RST) begin
        in_frame = 1'b0;
      end else begin
        if (!in_frame && Tx === 1'b0) begin
          in_frame = 1'b1;
          pos      = 0;
          glitches = 0;
          rx       = 8'h00;
          starts.push_back(cyc);
          check("frame_expected", exp_q.size() != 0, 1);
          cur = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        end
        if (in_frame) begin
          bidx = pos / DIV;
          if (Tx !== exp_bit(cur, bidx)) glitches++;
          if (pos % DIV == DIV / 2 && bidx >= 1 && bidx <= 8) rx[bidx-1] = Tx;
          pos++;
          if (pos == FRAME_CYC) begin
            check("frame_data", rx, cur);
            check("frame_bad_cycles", glitches, 0);
            in_frame = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] b, input bit accept, output int k);
    start = 1'b1;
    data  = b;
    if (accept) exp_q.push_back(b);
    @(posedge CLK); #1;
    k     = cyc;
    start = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((busy !== 1'b0 || in_frame || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check({name, "_drained"}, n < budget, 1);
    repeat (3) step();
  endtask

  initial begin : stimulus
    int k, k0, kx, idx, bad;

    // Reset state, then a quiet line
    repeat (3) step();
    check("rst_tx", Tx, 1);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    RST = 1'b0;
    bad = 0;
    repeat (50) begin
      step();
      if (Tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_bad_cycles", bad, 0);

    // Single byte 0x55: latency and busy fall
    idx = starts.size();
    push(8'h55, 1'b1, k);
    while (cyc < k + FRAME_CYC + 2) begin
      step();
      if (cyc == k + 1) begin
        check("lat_tx_before_start", Tx, 1);
        check("busy_after_push", busy, 1);
      end
      if (cyc == k + 2) check("lat_tx_start_bit", Tx, 0);
      if (cyc == k + FRAME_CYC) check("busy_in_stop", busy, 1);
    end
    check("busy_fall", busy, 0);
    check("start_cycle_55", (starts.size() > idx) ? starts[idx] : -1, k + 2);
    wait_idle("single", 400);

    // Back-to-back 0xA3, 0x0F
    idx = starts.size();
    push(8'hA3, 1'b1, k);
    push(8'h0F, 1'b1, kx);
    wait_idle("b2b", 600);
    check("b2b_frames", starts.size() - idx, 2);
    check("b2b_gap", (starts.size() >= idx + 2) ? starts[idx+1] - starts[idx] : -1, FRAME_CYC);

    // Six pushes into a depth-4 FIFO: sixth is dropped
    idx = starts.size();
    push(8'h11, 1'b1, k0);
    push(8'h22, 1'b1, kx);
    push(8'h33, 1'b1, kx);
    push(8'h44, 1'b1, kx);
    push(8'h5A, 1'b1, kx);
    check("ready_full", ready, 0);
    push(8'hE7, 1'b0, kx);
    while (cyc < k0 + FRAME_CYC + 1) begin
      step();
      if (cyc == k0 + FRAME_CYC) check("ready_held_low", ready, 0);
    end
    check("ready_after_pop", ready, 1);
    wait_idle("burst", 1200);
    check("burst_frames", starts.size() - idx, 5);

    // Reset during DATA bit 3 of 0xFF with two bytes queued
    idx = starts.size();
    push(8'hFF, 1'b1, k0);
    push(8'h12, 1'b1, kx);
    push(8'h34, 1'b1, kx);
    while (cyc < k0 + 44) step();
    RST = 1'b1;
    step();
    check("midrst_tx", Tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_ready", ready, 1);
    exp_q.delete();
    RST = 1'b0;
    bad = 0;
    repeat (300) begin
      step();
      if (Tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("postrst_quiet_cycles", bad, 0);
    check("postrst_frames", starts.size() - idx, 1);

`ifdef UART_TX_PARITY_EN
    // Even parity of 0x07 is 1
    idx = starts.size();
    push(8'h07, 1'b1, k);
    bad = 0;
    while (cyc < k + FRAME_CYC + 2) begin
      step();
      if (cyc == k + 2 + 80) check("par_d7_low", Tx, 0);
      if (cyc >= k + 2 + 90 && cyc < k + 2 + 100 && Tx !== 1'b1) bad++;
      if (cyc == k + FRAME_CYC) check("par_busy_in_stop", busy, 1);
    end
    check("par_bit_cycles", bad, 0);
    check("par_busy_fall", busy, 0);
    wait_idle("parity", 400);
    check("par_frames", starts.size() - idx, 1);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
